alu_mdu_seq: RTL and testbench

//  Parametrised successor to the single-cycle ALU: same 4-bit alu_control op set
//  and cf/of/zf flags at WIDTH bits, plus an iterative multiply/divide unit (MDU)

---
 rtl/alu_mdu_seq_if.sv | 30 +++
 rtl/alu_mdu_seq.sv | 199 +++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_seq_if.sv
// ALU/MDU execute-stage bus: operands, op codes, ALU result/flags, MDU handshake and HI/LO.
interface alu_mdu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] q;
    logic             cf;
    logic             of;
    logic             zf;
    logic             md_start;
    logic [1:0]       md_op;
    logic             mt_hi;
    logic             mt_lo;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output alu_a, alu_b, alu_control, md_start, md_op, mt_hi, mt_lo,
        input  q, cf, of, zf, md_busy, md_done, hi, lo
    );

    modport slave (
        input  alu_a, alu_b, alu_control, md_start, md_op, mt_hi, mt_lo,
        output q, cf, of, zf, md_busy, md_done, hi, lo
    );
endinterface

// File: rtl/alu_mdu_seq.sv
// Combinational ALU plus iterative radix-2 multiply/divide unit with HI/LO registers.
module alu_mdu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    alu_mdu_seq_if.slave bus
);
    localparam int unsigned WP1 = WIDTH + 1;
    localparam int unsigned W2  = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [SHW-1:0]   cnt;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] ph;
    logic [WIDTH-1:0] pl;
    logic [WIDTH-1:0] mb;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;

    // ALU: shared adder (subtracts for sub/subu/slt/sltu), shifter and logic ops
    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sum;
    logic             sub_op;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] q_c;
    logic             of_c;

    always_comb begin
        sub_op   = (bus.alu_control == 4'b1010) || (bus.alu_control == 4'b1011) ||
                   (bus.alu_control == 4'b1000) || (bus.alu_control == 4'b1001);
        b_add    = sub_op ? ~bus.alu_b : bus.alu_b;
        add_full = WP1'(bus.alu_a) + WP1'(b_add) + WP1'(sub_op);
        sum      = add_full[WIDTH-1:0];
        sh       = bus.alu_a[SHW-1:0];
        q_c      = sum;
        of_c     = 1'b0;
        case (bus.alu_control)
            4'b0000: q_c = bus.alu_a & bus.alu_b;
            4'b0001: q_c = bus.alu_b << sh;
            4'b0010: of_c = (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.alu_a[WIDTH-1]);
            4'b0011: q_c = bus.alu_a | bus.alu_b;
            4'b0100: q_c = ~(bus.alu_a | bus.alu_b);
            4'b0101: q_c = {bus.alu_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'b0110: q_c = sum;
            4'b0111: q_c = bus.alu_a ^ bus.alu_b;
            4'b1000: q_c = WIDTH'($signed(bus.alu_a) < $signed(bus.alu_b));
            4'b1001: q_c = WIDTH'(bus.alu_a < bus.alu_b);
            4'b1010: of_c = (bus.alu_a[WIDTH-1] != bus.alu_b[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.alu_a[WIDTH-1]);
            4'b1011: q_c = sum;
            4'b1100: q_c = WIDTH'($signed(bus.alu_b) >>> sh);
            4'b1101: q_c = bus.alu_b >> sh;
            default: q_c = sum;
        endcase
    end

    assign bus.q  = q_c;
    assign bus.of = of_c;
    assign bus.cf = add_full[WIDTH];
    assign bus.zf = (sum == '0);

    // MDU state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // MDU next-state: IDLE -> CALC (WIDTH cycles) -> FIX -> IDLE
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.md_start) state_n = S_CALC;
            S_CALC:  if (cnt == SHW'(WIDTH - 1)) state_n = S_FIX;
            S_FIX:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Operand magnitudes at latch time; signed ops are md_op[0]==0
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        sgn   = ~bus.md_op[0];
        a_neg = sgn & bus.alu_a[WIDTH-1];
        b_neg = sgn & bus.alu_b[WIDTH-1];
        abs_a = a_neg ? (~bus.alu_a + WIDTH'(1)) : bus.alu_a;
        abs_b = b_neg ? (~bus.alu_b + WIDTH'(1)) : bus.alu_b;
    end

    // One radix-2 step: shift-add multiply or restoring divide on {ph,pl}
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        mul_sum  = WP1'(ph) + (pl[0] ? WP1'(mb) : '0);
        div_sh   = {ph, pl[WIDTH-1]};
        div_diff = div_sh - WP1'(mb);
        div_ok   = ~div_diff[WIDTH];
        prod_fix = neg_q ? (~{ph, pl} + W2'(1)) : {ph, pl};
        quo_fix  = (neg_q && !div0) ? (~pl + WIDTH'(1)) : pl;
        rem_fix  = neg_r ? (~ph + WIDTH'(1)) : ph;
    end

    // MDU datapath, HI/LO and done pulse; reset aborts any op without writing HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_r   <= '0;
            ph     <= '0;
            pl     <= '0;
            mb     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.md_start) begin
                        cnt  <= '0;
                        op_r <= bus.md_op;
                        ph   <= '0;
                        div0 <= (bus.alu_b == '0);
                        if (bus.md_op[1]) begin
                            pl    <= abs_a;
                            mb    <= abs_b;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end else begin
                            pl    <= abs_b;
                            mb    <= abs_a;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= 1'b0;
                        end
                    end else begin
                        if (bus.mt_hi) hi_r <= bus.alu_a;
                        if (bus.mt_lo) lo_r <= bus.alu_a;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + SHW'(1);
                    if (op_r[1]) begin
                        ph <= div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        pl <= {pl[WIDTH-2:0], div_ok};
                    end else begin
                        ph <= mul_sum[WIDTH:1];
                        pl <= {mul_sum[0], pl[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    done_r <= 1'b1;
                    if (op_r[1]) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        hi_r <= prod_fix[W2-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.md_busy = (state != S_IDLE);
    assign bus.md_done = done_r;
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_mdu_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_mdu_seq_if #(.WIDTH(32)) b32 ();
    alu_mdu_seq_if #(.WIDTH(8))  b8 ();

    alu_mdu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    alu_mdu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start a 32-bit MDU op, wait for md_done and check latency, busy and HI/LO
    task automatic run32(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
        int lat;
        b32.md_op    = op;
        b32.alu_a    = a;
        b32.alu_b    = b;
        b32.md_start = 1'b1;
        tick();
        b32.md_start = 1'b0;
        check({tag, "_busy"}, 64'(b32.md_busy), 64'd1);
        lat = 0;
        while (!b32.md_done && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_busy_at_done"}, 64'(b32.md_busy), 64'd0);
        check({tag, "_hi"}, 64'(b32.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(b32.lo), 64'(exp_lo));
        tick();
        check({tag, "_done_pulse"}, 64'(b32.md_done), 64'd0);
    endtask

    initial begin
        int lat;
        int dones;
        rst = 1'b1;
        b32.alu_a = '0; b32.alu_b = '0; b32.alu_control = '0;
        b32.md_start = 1'b0; b32.md_op = '0; b32.mt_hi = 1'b0; b32.mt_lo = 1'b0;
        b8.alu_a = '0; b8.alu_b = '0; b8.alu_control = '0;
        b8.md_start = 1'b0; b8.md_op = '0; b8.mt_hi = 1'b0; b8.mt_lo = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_hi", 64'(b32.hi), 64'd0);
        check("rst_lo", 64'(b32.lo), 64'd0);
        check("rst_busy", 64'(b32.md_busy), 64'd0);
        check("rst_done", 64'(b32.md_done), 64'd0);

        // ALU corner cases
        b32.alu_control = 4'b0010; b32.alu_a = 32'h7FFF_FFFF; b32.alu_b = 32'h0000_0001; #1;
        check("add_q", 64'(b32.q), 64'h8000_0000);
        check("add_of", 64'(b32.of), 64'd1);
        check("add_cf", 64'(b32.cf), 64'd0);
        check("add_zf", 64'(b32.zf), 64'd0);
        b32.alu_control = 4'b1011; b32.alu_a = 32'd5; b32.alu_b = 32'd5; #1;
        check("subu_q", 64'(b32.q), 64'd0);
        check("subu_zf", 64'(b32.zf), 64'd1);
        check("subu_of", 64'(b32.of), 64'd0);
        b32.alu_control = 4'b1100; b32.alu_a = 32'd4; b32.alu_b = 32'h8000_0000; #1;
        check("sra_q", 64'(b32.q), 64'hF800_0000);
        b32.alu_control = 4'b0101; b32.alu_b = 32'h0000_1234; #1;
        check("lui_q", 64'(b32.q), 64'h1234_0000);
        b32.alu_control = 4'b1000; b32.alu_a = 32'hFFFF_FFFF; b32.alu_b = 32'd1; #1;
        check("slt_q", 64'(b32.q), 64'd1);
        b32.alu_control = 4'b1001; #1;
        check("sltu_q", 64'(b32.q), 64'd0);
        b32.alu_control = 4'b1010; b32.alu_a = 32'h8000_0000; b32.alu_b = 32'd1; #1;
        check("sub_of", 64'(b32.of), 64'd1);
        check("sub_q", 64'(b32.q), 64'h7FFF_FFFF);

        // Multiply / divide
        run32("mult", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run32("multu", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
        run32("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run32("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run32("div_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run32("div_zero", 2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);

        // mthi/mtlo together in IDLE
        b32.alu_a = 32'hCAFE_F00D; b32.mt_hi = 1'b1; b32.mt_lo = 1'b1;
        tick();
        b32.mt_hi = 1'b0; b32.mt_lo = 1'b0;
        check("mt_both_hi", 64'(b32.hi), 64'hCAFE_F00D);
        check("mt_both_lo", 64'(b32.lo), 64'hCAFE_F00D);

        // Start + mt_hi together in IDLE: start wins, HI/LO come from the op
        b32.md_op = 2'b01; b32.alu_a = 32'd3; b32.alu_b = 32'd4;
        b32.md_start = 1'b1; b32.mt_hi = 1'b1;
        tick();
        b32.md_start = 1'b0; b32.mt_hi = 1'b0;
        check("start_mt_hi_drop", 64'(b32.hi), 64'hCAFE_F00D);
        lat = 0;
        while (!b32.md_done && lat < 100) begin
            tick();
            lat++;
        end
        check("start_mt_lat", 64'(lat), 64'd33);
        check("start_mt_hi", 64'(b32.hi), 64'd0);
        check("start_mt_lo", 64'(b32.lo), 64'd12);

        // Busy: second start and mt_lo ignored, operand changes do not matter
        b32.md_op = 2'b00; b32.alu_a = 32'hFFFF_FFFD; b32.alu_b = 32'd5; b32.md_start = 1'b1;
        tick();
        b32.md_start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        b32.md_op = 2'b11; b32.alu_a = 32'hDEAD_BEEF; b32.alu_b = 32'd3;
        b32.md_start = 1'b1; b32.mt_lo = 1'b1;
        tick();
        b32.md_start = 1'b0; b32.mt_lo = 1'b0;
        lat = 10;
        while (!b32.md_done && lat < 100) begin
            tick();
            lat++;
        end
        check("busy_ign_lat", 64'(lat), 64'd33);
        check("busy_ign_hi", 64'(b32.hi), 64'hFFFF_FFFF);
        check("busy_ign_lo", 64'(b32.lo), 64'hFFFF_FFF1);
        tick();
        check("busy_ign_idle", 64'(b32.md_busy), 64'd0);

        // Reset mid-operation: aborted op never writes HI/LO
        b32.md_op = 2'b00; b32.alu_a = 32'hFFFF_FFFD; b32.alu_b = 32'd5; b32.md_start = 1'b1;
        tick();
        b32.md_start = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        rst = 1'b1;
        #1;
        check("midrst_hi", 64'(b32.hi), 64'd0);
        check("midrst_lo", 64'(b32.lo), 64'd0);
        check("midrst_busy", 64'(b32.md_busy), 64'd0);
        check("midrst_done", 64'(b32.md_done), 64'd0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (b32.md_done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        check("midrst_hi_after", 64'(b32.hi), 64'd0);
        check("midrst_busy_after", 64'(b32.md_busy), 64'd0);

        // WIDTH=8 instance
        b8.md_op = 2'b01; b8.alu_a = 8'hFF; b8.alu_b = 8'hFF; b8.md_start = 1'b1;
        tick();
        b8.md_start = 1'b0;
        check("w8_busy", 64'(b8.md_busy), 64'd1);
        lat = 0;
        while (!b8.md_done && lat < 50) begin
            tick();
            lat++;
        end
        check("w8_lat", 64'(lat), 64'd9);
        check("w8_hi", 64'(b8.hi), 64'hFE);
        check("w8_lo", 64'(b8.lo), 64'h01);
        b8.alu_a = 8'h5A; b8.mt_hi = 1'b1;
        tick();
        b8.mt_hi = 1'b0;
        check("w8_mthi", 64'(b8.hi), 64'h5A);
        check("w8_mthi_lo_kept", 64'(b8.lo), 64'h01);
        b8.alu_control = 4'b0010; b8.alu_a = 8'h7F; b8.alu_b = 8'h01; #1;
        check("w8_add_of", 64'(b8.of), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
